instr_uart_loader: RTL and testbench
====================================

INSTR_UART_LOADER -- requirements
Module: instr_uart_loader

Interface
REQ-001 Parameter INSTR_WIDTH, default 32: instruction word width; SHALL be a multiple of 8.
REQ-002 Parameter INSTR_DEPTH, default 256: instruction memory depth in words.
REQ-003 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 Parameter TIMEOUT_CYCLES, default 500000: maximum idle gap between bytes inside a frame (10 ms at 50 MHz).
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 rx_data  input  8  received byte from the UART receiver.
REQ-008 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  output  8  response byte to the UART transmitter.
REQ-010 tx_valid  output  1  response valid; held until accepted.
REQ-011 tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready.
REQ-012 wr_en  output  1  one-cycle instruction memory write strobe.
REQ-013 wr_addr  output  $clog2(INSTR_DEPTH)  write address.
REQ-014 wr_data  output  INSTR_WIDTH  write data.
REQ-015 mem_ext_en  output  1  high while the loader owns the instruction memory write port; the control FSM SHALL NOT fetch while it is high.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse on a successful load.
REQ-018 err  output  1  sticky error flag.

Function
REQ-019 The block SHALL have the states IDLE, COUNT, DATA, CHECK and RESP.
REQ-020 IDLE: rx_valid with rx_data==SYNC_BYTE -> COUNT and err cleared; all other bytes SHALL be ignored.
REQ-021 COUNT: the next byte N SHALL set the word count, with N=0 meaning INSTR_DEPTH; counts greater than INSTR_DEPTH SHALL be clamped to INSTR_DEPTH; on that byte -> DATA, address counter = 0, checksum = 0.
REQ-022 DATA: bytes SHALL be assembled MSB-first, INSTR_WIDTH/8 bytes per word; every data byte SHALL be XORed into the 8-bit checksum.
REQ-023 The last byte of a word accepted in cycle t SHALL produce wr_en=1 in cycle t+1, with wr_data = the assembled word and wr_addr = the current word index; the word index SHALL increment after each write.
REQ-024 After the N-th word is written, the block SHALL move to CHECK; addresses SHALL never wrap.
REQ-025 CHECK: the next byte SHALL be compared with the checksum. On a match -> RESP with tx_data=8'h06 (ACK) and done pulsed. On a mismatch -> RESP with tx_data=8'h15 (NAK) and err=1.
REQ-026 In COUNT, DATA or CHECK, a gap of TIMEOUT_CYCLES clocks with no rx_valid SHALL go to RESP with NAK and err=1; the gap counter SHALL restart on every rx_valid.
REQ-027 RESP: tx_valid SHALL be 1 with tx_data stable until the cycle of tx_valid && tx_ready; the block SHALL then return to IDLE.
REQ-028 rx_valid in RESP SHALL be dropped, including SYNC_BYTE.
REQ-029 mem_ext_en SHALL be 1 in COUNT, DATA and CHECK and 0 in IDLE and RESP.
REQ-030 Words already written before an error or reset SHALL stay in memory; no rollback.
REQ-031 At most one memory write per cycle; wr_en SHALL never assert outside DATA or the cycle after it.

Reset
REQ-032 While rst_n=0, the outputs SHALL be: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, tx_valid=0, tx_data=0, mem_ext_en=0, busy=0, done=0, err=0; the word, byte, checksum and timeout counters SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately; after release, the block SHALL wait for a new SYNC_BYTE.

Verification
REQ-034 Bytes A5, 02, 80 00 00 01, 40 00 00 02, checksum C3 -> mem[0]=32'h8000_0001, mem[1]=32'h4000_0002, ACK 06 sent, done pulses once, mem_ext_en low afterwards.
REQ-035 The same frame with checksum 00 -> both words written, NAK 15 sent, err=1; err stays 1 until the next A5 in IDLE.
REQ-036 Count 00 with 1024 bytes of 00 10 00 00 and checksum 00 -> 256 writes to addresses 0..255, no write beyond 255, ACK.
REQ-037 A5, 01, 12 34, then silence for TIMEOUT_CYCLES -> NAK, err=1, no write issued; leading 00 FF bytes before A5 are ignored.
REQ-038 rst_n pulsed low after the second data byte -> all outputs return to reset values at once; a following full frame loads correctly.
REQ-039 tx_ready held 0 for 20 cycles in RESP -> tx_valid and tx_data stay stable, an A5 byte sent during that time is dropped, and the block reaches IDLE one cycle after the handshake.

Source files
------------

// File: rtl/instr_uart_loader.sv
// UART-fed instruction memory loader: receives a framed stream of words, writes
// them into the instruction memory and answers with ACK/NAK on the transmitter.
module instr_uart_loader #(
   parameter int         INSTR_WIDTH    = 32,
   parameter int         INSTR_DEPTH    = 256,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 500000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [7:0]                     rx_data,
   input  logic                           rx_valid,
   output logic [7:0]                     tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic                           wr_en,
   output logic [$clog2(INSTR_DEPTH)-1:0] wr_addr,
   output logic [INSTR_WIDTH-1:0]         wr_data,
   output logic                           mem_ext_en,
   output logic                           busy,
   output logic                           done,
   output logic                           err
);

   localparam int BYTES = INSTR_WIDTH / 8;
   localparam int AW    = $clog2(INSTR_DEPTH);
   localparam int CW    = AW + 1;
   localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      DATA,
      CHECK,
      RESP
   } state_t;

   state_t state, next_state;

   logic [CW-1:0]          word_cnt;
   logic [CW-1:0]          word_idx;
   logic [BW-1:0]          byte_idx;
   logic [7:0]             checksum;
   logic [INSTR_WIDTH-1:0] shift_reg;
   logic [TW-1:0]          timer;

   logic [CW-1:0]          count_clamped;
   logic [INSTR_WIDTH-1:0] assembled;
   logic                   last_byte;
   logic                   last_word;
   logic                   timeout_hit;

   logic                   clr_err;
   logic                   send_ack;
   logic                   send_nak;
   logic                   load_cnt;
   logic                   take_data;
   logic                   write_word;

   assign busy       = (state != IDLE);
   assign mem_ext_en = (state == COUNT) || (state == DATA) || (state == CHECK);
   assign tx_valid   = (state == RESP);

   // A count byte of zero, or one larger than the memory, means "fill all of it".
   always_comb begin
      if (rx_data == 8'd0 || {24'd0, rx_data} > 32'(INSTR_DEPTH)) begin
         count_clamped = CW'(INSTR_DEPTH);
      end else begin
         count_clamped = CW'(rx_data);
      end
   end

   assign assembled   = (shift_reg << 8) | INSTR_WIDTH'(rx_data);
   assign last_byte   = (byte_idx == BW'(BYTES - 1));
   assign last_word   = (word_idx == word_cnt - CW'(1));
   assign timeout_hit = !rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      clr_err    = 1'b0;
      send_ack   = 1'b0;
      send_nak   = 1'b0;
      load_cnt   = 1'b0;
      take_data  = 1'b0;
      write_word = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
               next_state = COUNT;
               clr_err    = 1'b1;
            end
         end
         COUNT: begin
            if (rx_valid) begin
               next_state = DATA;
               load_cnt   = 1'b1;
            end else if (timeout_hit) begin
               next_state = RESP;
               send_nak   = 1'b1;
            end
         end
         DATA: begin
            if (rx_valid) begin
               take_data = 1'b1;
               if (last_byte) begin
                  write_word = 1'b1;
                  if (last_word) begin
                     next_state = CHECK;
                  end
               end
            end else if (timeout_hit) begin
               next_state = RESP;
               send_nak   = 1'b1;
            end
         end
         CHECK: begin
            if (rx_valid) begin
               next_state = RESP;
               if (rx_data == checksum) begin
                  send_ack = 1'b1;
               end else begin
                  send_nak = 1'b1;
               end
            end else if (timeout_hit) begin
               next_state = RESP;
               send_nak   = 1'b1;
            end
         end
         RESP: begin
            if (tx_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The write strobe is registered, so it lands one cycle after the word's last byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         tx_data   <= 8'd0;
         done      <= 1'b0;
         err       <= 1'b0;
         word_cnt  <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         checksum  <= 8'd0;
         shift_reg <= '0;
         timer     <= '0;
      end else begin
         wr_en <= write_word;
         done  <= send_ack;

         if (load_cnt) begin
            word_cnt  <= count_clamped;
            word_idx  <= '0;
            byte_idx  <= '0;
            checksum  <= 8'd0;
            shift_reg <= '0;
         end

         if (take_data) begin
            checksum  <= checksum ^ rx_data;
            shift_reg <= assembled;
            byte_idx  <= last_byte ? '0 : byte_idx + BW'(1);
         end

         if (write_word) begin
            wr_addr  <= word_idx[AW-1:0];
            wr_data  <= assembled;
            word_idx <= word_idx + CW'(1);
         end

         if (send_ack) begin
            tx_data <= ACK_BYTE;
         end else if (send_nak) begin
            tx_data <= NAK_BYTE;
         end

         if (clr_err) begin
            err <= 1'b0;
         end else if (send_nak) begin
            err <= 1'b1;
         end

         // The idle-gap timer only runs while a frame is open and restarts on every byte.
         if (mem_ext_en && !rx_valid) begin
            timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end
      end
   end

endmodule

// File: tb/tb_instr_uart_loader.sv
// Self-checking bench for instr_uart_loader: directed and random frames checked
// against a frame-level model of memory contents, responses and flags.
module tb_instr_uart_loader;

   localparam int         DEPTH   = 256;
   localparam int         TIMEOUT = 200;
   localparam logic [7:0] SYNC    = 8'hA5;
   localparam logic [7:0] ACK     = 8'h06;
   localparam logic [7:0] NAK     = 8'h15;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        mem_ext_en;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;
   int wr_cnt   = 0;
   int done_cnt = 0;

   logic [31:0] frame_words [$];
   logic [31:0] exp_mem [DEPTH];
   logic [31:0] obs_mem [DEPTH];

   instr_uart_loader #(
      .INSTR_WIDTH   (32),
      .INSTR_DEPTH   (DEPTH),
      .SYNC_BYTE     (SYNC),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .mem_ext_en(mem_ext_en),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory seen by the loader, plus a count of done pulses.
   always @(negedge clk) begin
      if (wr_en) begin
         obs_mem[wr_addr] = wr_data;
         wr_cnt++;
      end
      if (done) done_cnt++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired observed=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_wr_en"},      wr_en,      0);
      checkOutput({tag, "_wr_addr"},    wr_addr,    0);
      checkOutput({tag, "_wr_data"},    wr_data,    0);
      checkOutput({tag, "_tx_valid"},   tx_valid,   0);
      checkOutput({tag, "_tx_data"},    tx_data,    0);
      checkOutput({tag, "_mem_ext_en"}, mem_ext_en, 0);
      checkOutput({tag, "_busy"},       busy,       0);
      checkOutput({tag, "_done"},       done,       0);
      checkOutput({tag, "_err"},        err,        0);
   endtask

   // Called on a falling edge; returns on the falling edge after the byte was taken.
   task automatic sendByte(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = SYNC;
   endtask

   task automatic waitResponse(output logic [7:0] resp, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (tx_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      resp = tx_data;
   endtask

   // Sends one frame built from frame_words and checks it against the frame-level model.
   task automatic applyStimulus(input bit send_sync, input logic [7:0] cnt_byte, input int csum_sel,
                                input int max_gap, input int stall);
      logic [7:0] csum;
      logic [7:0] sent;
      logic [7:0] exp_resp;
      logic [7:0] resp;
      logic [7:0] b;
      int         n;
      int         wr_before;
      int         done_before;
      bit         seen;
      n = (cnt_byte == 8'd0 || int'(cnt_byte) > DEPTH) ? DEPTH : int'(cnt_byte);
      wr_before   = wr_cnt;
      done_before = done_cnt;
      csum        = 8'h00;
      tx_ready    = (stall == 0);
      if (send_sync) begin
         sendByte(SYNC, 0);
         checkOutput("sync_busy", busy, 1);
         checkOutput("sync_err_clear", err, 0);
      end
      sendByte(cnt_byte, $urandom_range(0, max_gap));
      checkOutput("count_ext_en", mem_ext_en, 1);
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = frame_words[w][31 - 8*k -: 8];
            csum = csum ^ b;
            sendByte(b, $urandom_range(0, max_gap));
         end
         checkOutput("wr_en", wr_en, 1);
         checkOutput("wr_addr", wr_addr, w);
         checkOutput("wr_data", wr_data, frame_words[w]);
         exp_mem[w] = frame_words[w];
      end
      sent     = (csum_sel < 0) ? csum : 8'(csum_sel);
      exp_resp = (sent == csum) ? ACK : NAK;
      sendByte(sent, $urandom_range(0, max_gap));
      waitResponse(resp, seen);
      checkOutput("resp_seen", seen, 1);
      checkOutput("resp_byte", resp, exp_resp);
      checkOutput("resp_ext_en", mem_ext_en, 0);
      for (int c = 0; c < stall; c++) begin
         if (c == 5) begin
            rx_data  = SYNC;
            rx_valid = 1'b1;
         end
         @(negedge clk);
         rx_valid = 1'b0;
         checkOutput("stall_tx_valid", tx_valid, 1);
         checkOutput("stall_tx_data", tx_data, exp_resp);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      checkOutput("idle_after_hs", busy, 0);
      checkOutput("tx_valid_drop", tx_valid, 0);
      checkOutput("err_flag", err, exp_resp == NAK);
      checkOutput("done_pulses", done_cnt - done_before, exp_resp == ACK);
      checkOutput("write_count", wr_cnt - wr_before, n);
      for (int i = 0; i < n; i++) begin
         checkOutput("mem_word", obs_mem[i], exp_mem[i]);
      end
   endtask

   initial begin
      int wr_before;
      int nw;
      int sel;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tx_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         exp_mem[i] = 32'd0;
         obs_mem[i] = 32'd0;
      end

      repeat (2) @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Two-word frame with the correct checksum.
      frame_words = {32'h8000_0001, 32'h4000_0002};
      applyStimulus(1'b1, 8'd2, -1, 0, 0);

      // Same frame with a zero checksum: words still land, NAK, sticky err.
      applyStimulus(1'b1, 8'd2, 0, 0, 0);
      sendByte(8'h00, 1);
      sendByte(8'h3C, 0);
      checkOutput("err_sticky", err, 1);
      checkOutput("err_sticky_idle", busy, 0);
      sendByte(SYNC, 2);
      checkOutput("err_cleared_by_sync", err, 0);
      checkOutput("busy_after_sync", busy, 1);
      frame_words = {$urandom, $urandom, $urandom};
      applyStimulus(1'b0, 8'd3, -1, 2, 0);

      // Random frames with random gaps and a mix of good and bad checksums.
      for (int f = 0; f < 5; f++) begin
         nw = $urandom_range(1, 8);
         frame_words = {};
         for (int w = 0; w < nw; w++) frame_words.push_back($urandom);
         sel = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 255));
         applyStimulus(1'b1, 8'(nw), sel, 3, 0);
      end

      // Count byte zero fills the whole memory.
      frame_words = {};
      for (int w = 0; w < DEPTH; w++) frame_words.push_back(32'h0010_0000);
      applyStimulus(1'b1, 8'h00, -1, 0, 0);

      // Noise before sync, then a partial word followed by silence.
      sendByte(8'h00, 0);
      sendByte(8'hFF, 0);
      checkOutput("noise_ignored", busy, 0);
      wr_before = wr_cnt;
      sendByte(SYNC, 0);
      sendByte(8'h01, 0);
      sendByte(8'h12, 0);
      sendByte(8'h34, 0);
      repeat (TIMEOUT - 1) @(negedge clk);
      checkOutput("timeout_not_early", tx_valid, 0);
      @(negedge clk);
      checkOutput("timeout_tx_valid", tx_valid, 1);
      checkOutput("timeout_nak", tx_data, NAK);
      checkOutput("timeout_err", err, 1);
      checkOutput("timeout_no_write", wr_cnt - wr_before, 0);
      @(negedge clk);
      checkOutput("timeout_idle", busy, 0);

      // Reset in the middle of a frame, then a clean reload.
      sendByte(SYNC, 0);
      sendByte(8'h02, 0);
      sendByte(8'h80, 0);
      sendByte(8'h00, 0);
      rst_n = 1'b0;
      #1;
      checkReset("midframe_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      frame_words = {$urandom, $urandom};
      applyStimulus(1'b1, 8'd2, -1, 1, 0);

      // Transmitter stalls for 20 cycles while a stray sync byte arrives.
      frame_words = {$urandom};
      applyStimulus(1'b1, 8'd1, -1, 0, 20);
      @(negedge clk);
      checkOutput("stray_sync_dropped", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
